hazard_unit: RTL

Pipeline hazard controller for the 5-stage 64-bit RISC core, sitting beside the ID stage and directly upstream of the operand forwarding logic. It detects load-use hazards that forwarding cannot cover, freezes the whole pipeline while the MEM-stage data cache access is outstanding, and flushes IF/ID on a taken branch resolved in EX. Stall and flush controls are produced in the same cycle the condition is seen. A small FSM tracks stall and wait episodes and carries an optional cycle-accurate performance counter set.

---
 rtl/hazard_unit_pkg.sv | 25 ++
 rtl/hazard_perf_counters.sv | 29 ++
 rtl/hazard_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_unit_pkg;

    // 2'd3 is never produced; the FSM treats it like RUN.
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } hazardStateT;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Load in EX writes a register the ID instruction reads; r0 never counts.
    function automatic logic loadUseMatch(
        input logic       memReadEx,
        input logic [4:0] destEx,
        input logic [4:0] rsId,
        input logic [4:0] rtId,
        input logic       usesRtId
    );
        return memReadEx && (destEx != REG_ZERO) &&
               ((destEx == rsId) || (usesRtId && (destEx == rtId)));
    endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Free-running 32-bit wrapping event counters for hazard activity.
// Only instantiated when HAZARD_PERF_EN is defined.
module hazard_perf_counters
    import hazard_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        loadUseStall,
    input  logic        freeze,
    input  logic        flush,
    output logic [31:0] perfLoadUse,
    output logic [31:0] perfMemWait,
    output logic [31:0] perfFlush
);

    // Count one per cycle each event is asserted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perfLoadUse <= 32'd0;
            perfMemWait <= 32'd0;
            perfFlush   <= 32'd0;
        end else begin
            if (loadUseStall) perfLoadUse <= perfLoadUse + 32'd1;
            if (freeze)       perfMemWait <= perfMemWait + 32'd1;
            if (flush)        perfFlush   <= perfFlush + 32'd1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall, MEM-stage freeze on a data
// cache miss, IF/ID flush on a taken branch. Controls are combinational.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
//
// state      | meaning
// -----------+----------------------------------------------------------
// RUN        | normal issue; all hazard checks active
// LOAD_STALL | bubble sits in EX; load-use check masked for one cycle
// MEM_WAIT   | data cache access outstanding; whole pipeline frozen
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int WAIT_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [4:0]                inRegisterRsId,
    input  logic [4:0]                inRegisterRtId,
    input  logic                      inUsesRtId,
    input  logic                      inMemReadEx,
    input  logic [4:0]                inDestRegisterEx,
    input  logic                      inBranchTakenEx,
    input  logic                      inDcacheReq,
    input  logic                      inDcacheReady,
    output logic                      outStallPc,
    output logic                      outStallIfId,
    output logic                      outBubbleIdEx,
    output logic                      outFlushIfId,
    output logic                      outFreeze,
    output logic [1:0]                outState,
    output logic [WAIT_CNT_WIDTH-1:0] outWaitCycles,
    output logic [31:0]               outPerfLoadUse,
    output logic [31:0]               outPerfMemWait,
    output logic [31:0]               outPerfFlush
);

    // The data width is carried for uniformity with the rest of the core.
    if (BUS_DATA_WIDTH < 1) begin : gBadWidth
        $error("hazard_unit: BUS_DATA_WIDTH must be positive");
    end

    hazardStateT state;
    hazardStateT stateNext;
    logic        loadUseHit;
    logic        memMiss;
    logic        waitDone;

    assign loadUseHit = loadUseMatch(inMemReadEx, inDestRegisterEx,
                                     inRegisterRsId, inRegisterRtId, inUsesRtId);
    assign memMiss    = inDcacheReq && !inDcacheReady;
    // A ready pulse only ends the wait when it belongs to an active access.
    assign waitDone   = inDcacheReq && inDcacheReady;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= stateNext;
    end

    // Next state and controls; priority is miss > branch > load-use.
    always_comb begin
        stateNext     = RUN;
        outStallPc    = 1'b0;
        outStallIfId  = 1'b0;
        outBubbleIdEx = 1'b0;
        outFlushIfId  = 1'b0;
        outFreeze     = 1'b0;
        if (reset_n) begin
            if (memMiss || ((state == MEM_WAIT) && !waitDone)) begin
                outFreeze = 1'b1;
                stateNext = MEM_WAIT;
            end else if (inBranchTakenEx) begin
                outFlushIfId  = 1'b1;
                outBubbleIdEx = 1'b1;
                stateNext     = RUN;
            end else if (loadUseHit && (state != LOAD_STALL)) begin
                outStallPc    = 1'b1;
                outStallIfId  = 1'b1;
                outBubbleIdEx = 1'b1;
                stateNext     = LOAD_STALL;
            end else begin
                stateNext = RUN;
            end
        end
    end

    assign outState = state;

    // Wait-episode length: cleared on entry, saturating count while waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outWaitCycles <= '0;
        end else if (state == MEM_WAIT) begin
            if (outWaitCycles != '1)
                outWaitCycles <= outWaitCycles + WAIT_CNT_WIDTH'(1);
        end else if (stateNext == MEM_WAIT) begin
            outWaitCycles <= '0;
        end
    end

`ifdef HAZARD_PERF_EN
    hazard_perf_counters uPerf (
        .clk          (clk),
        .reset_n      (reset_n),
        .loadUseStall (outStallPc),
        .freeze       (outFreeze),
        .flush        (outFlushIfId),
        .perfLoadUse  (outPerfLoadUse),
        .perfMemWait  (outPerfMemWait),
        .perfFlush    (outPerfFlush)
    );
`else
    assign outPerfLoadUse = 32'd0;
    assign outPerfMemWait = 32'd0;
    assign outPerfFlush   = 32'd0;
`endif

endmodule
